// File: rtl/dram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dram_responder_pkg
//  Purpose : Shared definitions for the DRAM responder slice.
//            MIG-style command opcodes and the default DDR port widths
//            used by the ORAM DRAM interface.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package dram_responder_pkg;

  // MIG command opcodes
  localparam logic [2:0] DDR3CMD_Write = 3'b000;
  localparam logic [2:0] DDR3CMD_Read  = 3'b001;

  // Default DDR port geometry
  localparam int DDRAWidthDef = 28;
  localparam int DDRCWidthDef = 3;
  localparam int DDRDWidthDef = 512;
  localparam int DDRMWidthDef = DDRDWidthDef / 8;

endpackage : dram_responder_pkg
`default_nettype wire

// File: rtl/dram_resp_wbuf.sv
`default_nettype none
// ============================================================================
//  Module  : dram_resp_wbuf
//  Purpose : Write-data FIFO for the DRAM responder. Each entry holds one
//            burst beat and its byte write-mask. Depth must be a power of
//            two and at least 2 so the pointers wrap naturally.
//  Ports   : Clock, Reset        - clock, synchronous active-high reset
//            push, pushData,
//            pushMask            - enqueue (caller qualifies with ~full)
//            pop                 - dequeue (caller qualifies with ~empty)
//            headData, headMask  - oldest entry
//            full, empty         - occupancy flags
//  Rev     : 1.0  initial release
// ============================================================================
module dram_resp_wbuf #(
  parameter int DWidth = 512,
  parameter int MWidth = 64,
  parameter int Depth  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              push,
  input  logic [DWidth-1:0] pushData,
  input  logic [MWidth-1:0] pushMask,
  input  logic              pop,
  output logic [DWidth-1:0] headData,
  output logic [MWidth-1:0] headMask,
  output logic              full,
  output logic              empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [DWidth-1:0] r_dataMem [Depth];
  logic [MWidth-1:0] r_maskMem [Depth];
  logic [PtrW-1:0]   r_wrPtr;
  logic [PtrW-1:0]   r_rdPtr;
  logic [CntW-1:0]   r_count;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge Clock) begin
    if (push) begin
      r_dataMem[r_wrPtr] <= pushData;
      r_maskMem[r_wrPtr] <= pushMask;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + PtrW'(1);
      if (pop)  r_rdPtr <= r_rdPtr + PtrW'(1);
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign headData = r_dataMem[r_rdPtr];
  assign headMask = r_maskMem[r_rdPtr];
  assign full     = (r_count == CntW'(Depth));
  assign empty    = (r_count == '0);

endmodule : dram_resp_wbuf
`default_nettype wire

// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
//  Module  : dram_responder
//  Purpose : Cycle-accurate stand-in for the DDR3 controller behind the
//            ORAM top. Accepts MIG-style read/write commands and write
//            beats, backs them with an on-chip burst array, and returns
//            read beats a fixed ReadLatency cycles after acceptance.
//  Ports   : Clock, Reset                         - clock, sync active-high
//            DRAMAddress, DRAMCommand,
//            DRAMCommandValid / DRAMCommandReady  - command channel
//            DRAMWriteData, DRAMWriteMask,
//            DRAMWriteDataValid / Ready           - write-beat channel
//            DRAMReadData, DRAMReadDataValid      - read return (no stall)
//            DRAMError                            - sticky illegal-command
//                                                   flag (optional)
//  Macro   : DRAM_RESP_ERRCHK_EN - adds DRAMError; drops commands with an
//            unknown opcode or a non burst-aligned address.
//  Rev     : 1.0  initial release
// ============================================================================
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int DDRAWidth   = DDRAWidthDef,
  parameter int DDRCWidth   = DDRCWidthDef,
  parameter int DDRDWidth   = DDRDWidthDef,
  parameter int DDRMWidth   = DDRMWidthDef,
  parameter int MemAWidth   = 10,
  parameter int AddrShift   = 3,
  parameter int ReadLatency = 8,
  parameter int WDBufDepth  = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DDRAWidth-1:0] DRAMAddress,
  input  logic [DDRCWidth-1:0] DRAMCommand,
  input  logic                 DRAMCommandValid,
  output logic                 DRAMCommandReady,
  input  logic [DDRDWidth-1:0] DRAMWriteData,
  input  logic [DDRMWidth-1:0] DRAMWriteMask,
  input  logic                 DRAMWriteDataValid,
  output logic                 DRAMWriteDataReady,
  output logic [DDRDWidth-1:0] DRAMReadData,
  output logic                 DRAMReadDataValid
`ifdef DRAM_RESP_ERRCHK_EN
  ,
  output logic                 DRAMError
`endif
);

  localparam int MemDepth = 1 << MemAWidth;
  localparam int PipeLen  = ReadLatency - 1;   // stages before the output reg

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  logic [MemAWidth-1:0] w_idx;
  logic                 w_isWrite;
  logic                 w_illegal;
  logic                 w_cmdFire;
  logic                 w_wrFire;
  logic                 w_rdFire;
  logic                 w_unusedAddr;

  assign w_idx     = DRAMAddress[AddrShift+MemAWidth-1:AddrShift];
  assign w_isWrite = (DRAMCommand == DDR3CMD_Write);

  // Upper address bits alias; low bits are only examined by the error check.
  assign w_unusedAddr = ^{DRAMAddress[DDRAWidth-1:AddrShift+MemAWidth],
                          DRAMAddress[AddrShift-1:0]};

`ifdef DRAM_RESP_ERRCHK_EN
  assign w_illegal = ((DRAMCommand != DDR3CMD_Write) && (DRAMCommand != DDR3CMD_Read))
                   || (DRAMAddress[AddrShift-1:0] != '0);
`else
  assign w_illegal = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Ready generation. r_portEn holds both readies low through reset and
  // lets them rise on the first cycle after Reset is released.
  // --------------------------------------------------------------------------
  logic r_portEn;

  always_ff @(posedge Clock) begin
    if (Reset) r_portEn <= 1'b0;
    else       r_portEn <= 1'b1;
  end

  logic                 w_fifoFull;
  logic                 w_fifoEmpty;
  logic [DDRDWidth-1:0] w_headData;
  logic [DDRMWidth-1:0] w_headMask;
  logic                 w_push;

  // A write command needs a beat already buffered; a beat pushed in the same
  // cycle is not visible until the next one. Every other opcode is a read.
  assign DRAMCommandReady   = r_portEn & (w_isWrite ? ~w_fifoEmpty : 1'b1);
  // No bypass: a full FIFO refuses even when it is popped this cycle.
  assign DRAMWriteDataReady = r_portEn & ~w_fifoFull;

  assign w_cmdFire = DRAMCommandValid & DRAMCommandReady;
  assign w_wrFire  = w_cmdFire &  w_isWrite & ~w_illegal;
  assign w_rdFire  = w_cmdFire & ~w_isWrite & ~w_illegal;
  assign w_push    = DRAMWriteDataValid & DRAMWriteDataReady;

  // --------------------------------------------------------------------------
  // Write-data buffer
  // --------------------------------------------------------------------------
  dram_resp_wbuf #(
    .DWidth (DDRDWidth),
    .MWidth (DDRMWidth),
    .Depth  (WDBufDepth)
  ) u_wbuf (
    .Clock    (Clock),
    .Reset    (Reset),
    .push     (w_push),
    .pushData (DRAMWriteData),
    .pushMask (DRAMWriteMask),
    .pop      (w_wrFire),
    .headData (w_headData),
    .headMask (w_headMask),
    .full     (w_fifoFull),
    .empty    (w_fifoEmpty)
  );

  // --------------------------------------------------------------------------
  // Backing store. Contents survive reset. A write committed at T is seen
  // by a read accepted at T+1 because the read samples the array
  // combinationally in its own acceptance cycle.
  // --------------------------------------------------------------------------
  logic [DDRDWidth-1:0] r_mem [MemDepth];

  always_ff @(posedge Clock) begin
    if (w_wrFire) begin
      for (int b = 0; b < DDRMWidth; b++) begin
        // Mask bit set means the byte is preserved.
        if (!w_headMask[b]) begin
          r_mem[w_idx][b*8 +: 8] <= w_headData[b*8 +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipeline: PipeLen data/valid stages followed by the output register
  // gives exactly ReadLatency cycles from acceptance to DRAMReadDataValid.
  // It never stalls, so any number of reads may be outstanding.
  // --------------------------------------------------------------------------
  logic [DDRDWidth-1:0] r_rdData [PipeLen];
  logic [PipeLen-1:0]   r_rdVld;
  logic [DDRDWidth-1:0] r_readData;
  logic                 r_readValid;

  always_ff @(posedge Clock) begin
    if (w_rdFire) r_rdData[0] <= r_mem[w_idx];
    for (int k = 1; k < PipeLen; k++) begin
      r_rdData[k] <= r_rdData[k-1];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rdVld <= '0;
    end else begin
      r_rdVld[0] <= w_rdFire;
      for (int k = 1; k < PipeLen; k++) begin
        r_rdVld[k] <= r_rdVld[k-1];
      end
    end
  end

  // The data output only loads with a valid beat so it holds otherwise.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_readValid <= 1'b0;
      r_readData  <= '0;
    end else begin
      r_readValid <= r_rdVld[PipeLen-1];
      if (r_rdVld[PipeLen-1]) r_readData <= r_rdData[PipeLen-1];
    end
  end

  assign DRAMReadData      = r_readData;
  assign DRAMReadDataValid = r_readValid;

  // --------------------------------------------------------------------------
  // Optional sticky error flag
  // --------------------------------------------------------------------------
`ifdef DRAM_RESP_ERRCHK_EN
  logic r_error;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_error <= 1'b0;
    end else if (w_cmdFire && w_illegal) begin
      r_error <= 1'b1;
`ifdef SIMULATION
      $display("dram_responder: illegal command opcode=%b addr=%h dropped",
               DRAMCommand, DRAMAddress);
`endif
    end
  end

  assign DRAMError = r_error;
`endif

endmodule : dram_responder
`default_nettype wire

// File: doc/dram_responder.md
Name: dram_responder

Overview:
- Cycle-accurate, synthesizable DRAM responder for the ORAM top's MIG-style DRAM port.
- Accepts read/write burst commands and write-data beats, backs them with an on-chip array, and returns read bursts after a fixed latency.
- Sits in place of the DDR3 controller in simulation and FPGA self-test builds, wired directly to the ORAM DRAM command, read and write interfaces.

Parameters:
- DDRAWidth, 28, command address width.
- DDRCWidth, 3, command width; 3'b000 = write, 3'b001 = read.
- DDRDWidth, 512, burst data width (one beat per command).
- DDRMWidth, 64, byte write-mask width (DDRDWidth/8).
- MemAWidth, 10, log2 of backing-store depth in bursts.
- AddrShift, 3, address LSBs dropped to form the burst index (8 words per burst).
- ReadLatency, 8, cycles from read-command acceptance to DRAMReadDataValid; legal range 2..64.
- WDBufDepth, 4, write-data buffer depth in beats (power of 2).

Ports:
- Clock  in  1  single clock.
- Reset  in  1  synchronous, active-high.
- DRAMAddress  in  DDRAWidth  command address.
- DRAMCommand  in  DDRCWidth  command opcode.
- DRAMCommandValid  in  1  command valid.
- DRAMCommandReady  out  1  command accepted when Valid&Ready.
- DRAMWriteData  in  DDRDWidth  write beat.
- DRAMWriteMask  in  DDRMWidth  1 = byte NOT written.
- DRAMWriteDataValid  in  1  write beat valid.
- DRAMWriteDataReady  out  1  write beat accepted when Valid&Ready.
- DRAMReadData  out  DDRDWidth  read beat.
- DRAMReadDataValid  out  1  read beat valid; no backpressure.
- DRAMError  out  1  sticky error; present only with DRAM_RESP_ERRCHK_EN.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high; it is sampled only on the rising edge of Clock.
- Reset values:
  - DRAMCommandReady = 0, DRAMWriteDataReady = 0, DRAMReadDataValid = 0, DRAMReadData = 0, DRAMError = 0.
  - Write buffer emptied; read pipeline flushed.
  - Backing-store contents are not cleared.
  - Both ready outputs rise on the first cycle after Reset deasserts.
- Reset mid-operation: in-flight reads are discarded with no valid beat; buffered write beats are dropped.
- Burst index: idx = DRAMAddress[AddrShift+MemAWidth-1 : AddrShift]. Upper address bits are ignored (aliasing).
- Write-data buffer: FIFO of WDBufDepth entries, each holding data and mask.
  - DRAMWriteDataReady = ~full.
  - Write beats may arrive before, with, or after their command.
  - Full with a pop in the same cycle: ready still 0 (no bypass).
- DRAMCommandReady:
  - Read command: 1.
  - Write command: FIFO nonempty, i.e. a beat is present at the start of the cycle. A beat arriving in the same cycle is not usable.
  - Any other opcode: 1; treated as a read.
- Write commit: on accepted write at cycle T, pop the FIFO head and update mem[idx] bytewise for mask bits = 0. The new contents are visible to a read accepted at T+1.
- Read: on accepted read at cycle T, the array is read at T. DRAMReadData/DRAMReadDataValid are asserted for exactly one cycle at T+ReadLatency.
  - Reads are returned strictly in order.
  - Back-to-back reads produce back-to-back valid beats.
  - Read pipeline is a ReadLatency-deep valid shift register plus data pipeline. It never stalls, so unlimited reads may be outstanding.
- Read-data hold: DRAMReadData holds its last value when valid is 0.
- Simultaneous write-beat push and write-command pop: both occur; count unchanged.

Optional Feature:
- Macro: DRAM_RESP_ERRCHK_EN.
- Defined:
  - DRAMError port exists.
  - Any accepted command with an opcode other than 000/001, or with DRAMAddress[AddrShift-1:0] != 0, sets DRAMError (sticky until Reset). That command is dropped: no array access, no read beat, no FIFO pop.
  - A $display is issued under SIMULATION.
- Undefined:
  - Port absent.
  - Low address bits are ignored; illegal opcodes behave as reads.

Decomposition:
- Shared package (DDR3SDRAMLocal-style header): opcode constants DDR3CMD_Write = 3'b000 and DDR3CMD_Read = 3'b001, plus DDR width defaults.
- One sub-module: dram_resp_wbuf, the parameterised data+mask FIFO with full/empty flags. The array and read pipeline stay in the top.

Test Plan:
- Write then read: beat 0xA5 repeated, mask 0, address 0x40, then read 0x40 at T → valid at T+8 with data 0xA5…; no other valid cycles.
- Byte mask: write all-ones, then write 0x00 with mask 0x…FE, then read → byte0 = 0x00, all other bytes 0xFF.
- Write command before data: command valid with FIFO empty → CommandReady = 0 until the beat is pushed; accepted the cycle after the push.
- Back-to-back pipelining: 4 reads on consecutive cycles at addresses 0, 8, 16, 24 → 4 consecutive valid beats, in order, starting T+8.
- FIFO full: push 4 beats with no commands → WriteDataReady = 0 from the 4th push on; one write command → ready returns the next cycle.
- Reset mid-read: read accepted, Reset pulsed at T+3 → no valid beat at T+8; all outputs 0; DRAMError cleared (ERRCHK: prior misaligned address 0x41 had set it).
